branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Sequences control-flow resolution for the 5-stage PPU. It takes the EX-stage branch/jump
//  decode and the taken flag from the branch condition handler. It stalls on load-use operand hazards,
//  then issues a registered PC redirect plus IF/ID/EX flush, and keeps saturating branch statistics.
//  Sits between the condition handler/EX stage and the PC mux and pipeline-register enables.
// PARAMETERS
//  STALL_CYCLES  1   cycles to hold IF/ID/EX when the branch operand depends on a load in MEM (>=1)
//  CNT_W         16  width of statistics counters
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous reset, active low
//  ex_valid       in   1      EX holds a live instruction
//  ex_is_branch   in   1      EX op is conditional branch (opcode 1100011)
//  ex_is_jal      in   1      EX op is JAL (1101111)
//  ex_is_jalr     in   1      EX op is JALR (1100111)
//  ex_load_dep    in   1      branch/jalr source produced by load currently in MEM
//  cond_taken     in   1      branch condition result from condition handler
//  ex_target      in   32     computed target address
//  stat_clr       in   1      synchronous clear of statistics
//  pc_sel         out  1      1 = PC takes pc_target
//  pc_target      out  32     latched redirect target
//  stall_if/stall_id/stall_ex out 1 each  hold pipeline registers
//  flush_if/flush_id/flush_ex out 1 each  insert bubble into stage register
//  trap_misalign  out  1      one-cycle pulse, taken target with target[1:0]!=0
//  branch_cnt     out  CNT_W  resolved control-flow ops
//  taken_cnt      out  CNT_W  redirects issued
// BEHAVIOUR
//  - Reset (async, rst_n=0): state RUN; all 1-bit outputs 0; pc_target 0; counters 0.
//  - cf = ex_valid & (ex_is_branch|ex_is_jal|ex_is_jalr); take = jal|jalr|(branch&cond_taken).
//  - ex_is_jal does not stall on ex_load_dep. Only branch and jalr stall.
//  - RUN:
//    - cf & ex_load_dep & !jal -> STALL; load stall_cnt = STALL_CYCLES-1.
//    - cf & take & target[1:0]==0 -> REDIRECT; latch ex_target; branch_cnt++, taken_cnt++.
//    - cf & take & misaligned -> trap_misalign=1 next cycle; no redirect; branch_cnt++; stay RUN.
//    - cf & !take -> branch_cnt++; stay RUN.
//  - STALL: stall_if=stall_id=stall_ex=1, flush_ex=0 (EX input held stable).
//    - Decrement stall_cnt; at 0 -> RUN, which re-evaluates the held instruction.
//    - If ex_load_dep is still 1 at that point, another STALL is entered. No counter increments in STALL.
//  - REDIRECT (exactly 1 cycle): pc_sel=1, flush_if=flush_id=flush_ex=1.
//    - The instruction that entered EX this cycle is killed; EX inputs are ignored; -> RUN.
//  - Latency: cf resolved in EX at cycle t -> pc_sel/flush asserted at t+1. Taken penalty is 3 bubbles.
//  - All outputs are registered (decoded from state/latched regs); no comb path from inputs to outputs.
//  - Counters saturate at 2^CNT_W-1. stat_clr has priority over a same-cycle increment.
//  - ex_valid=0 with cf flags set: treated as no-op.
//  - Multiple of jal/jalr/branch set at once: take computed as above, still one resolution.
//  - Async reset mid-STALL/REDIRECT: immediate return to RUN, outputs 0, latched target discarded.
// STRUCTURE
//  - Shared include ppu_defs.vh: opcodes OPC_BRANCH/OPC_JAL/OPC_JALR, state encodings
//    ST_RUN=2'd0, ST_STALL=2'd1, ST_REDIRECT=2'd2.
//  - One sub-module: sat_counter #(W) (clk, rst_n, clr, inc, q). Two instances: branch_cnt, taken_cnt.
//  - FSM, stall counter and target latch live in this module.
// TESTING
//  1. Reset: rst_n=0 mid-REDIRECT -> pc_sel=0, all flushes 0, counters 0, state RUN next edge.
//  2. BEQ taken: branch=1, cond_taken=1, target=0x100 at t -> t+1 pc_sel=1, pc_target=0x100,
//     flush_if/id/ex=1; t+2 all 0; taken_cnt=1.
//  3. BNE not taken: cond_taken=0 -> no pc_sel/flush; branch_cnt=1, taken_cnt=0.
//  4. Load-use with STALL_CYCLES=2: branch with ex_load_dep=1 -> stalls for 2 cycles, then
//     (dep=0, taken, 0x200) -> redirect one cycle later; branch_cnt increments once.
//  5. JALR taken to 0x102 -> trap_misalign pulse 1 cycle, no pc_sel; JAL with ex_load_dep=1 -> no stall.
//  6. CNT_W=2: 5 taken jumps -> taken_cnt saturates at 3; stat_clr with same-cycle jump -> counters 0.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared types and helpers for the branch redirect controller
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-stage control-flow resolution: load-use stall, redirect/flush, stats
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic             ex_load_dep,
    input  logic             cond_taken,
    input  logic [31:0]      ex_target,
    input  logic             stat_clr,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             trap_misalign,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int SCW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    state_e          state_q;
    logic [SCW-1:0]  stall_cnt_q;
    logic [31:0]     target_q;
    logic            pc_sel_q;
    logic            stall_q;
    logic            flush_q;
    logic            trap_q;

    logic cf;
    logic take;
    logic stall_req;
    logic aligned;
    logic run_resolve;

    assign cf          = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
    assign take        = ex_is_jal | ex_is_jalr | (ex_is_branch & cond_taken);
    // JAL has no register source, so a pending load never holds it.
    assign stall_req   = cf & ex_load_dep & ~ex_is_jal;
    assign aligned     = is_aligned(ex_target);
    assign run_resolve = (state_q == ST_RUN) & cf & ~stall_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            target_q    <= '0;
            pc_sel_q    <= 1'b0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            pc_sel_q <= 1'b0;
            stall_q  <= 1'b0;
            flush_q  <= 1'b0;
            trap_q   <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (stall_req) begin
                        state_q     <= ST_STALL;
                        stall_cnt_q <= SCW'(STALL_CYCLES - 1);
                        stall_q     <= 1'b1;
                    end else if (cf && take && aligned) begin
                        state_q  <= ST_REDIRECT;
                        target_q <= ex_target;
                        pc_sel_q <= 1'b1;
                        flush_q  <= 1'b1;
                    end else if (cf && take) begin
                        trap_q <= 1'b1;
                    end
                end
                ST_STALL: begin
                    // Returning to RUN re-evaluates the instruction still held in EX.
                    if (stall_cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        stall_cnt_q <= stall_cnt_q - SCW'(1);
                        stall_q     <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (run_resolve),
        .q     (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (run_resolve & take & aligned),
        .q     (taken_cnt)
    );

    assign pc_sel        = pc_sel_q;
    assign pc_target     = target_q;
    assign stall_if      = stall_q;
    assign stall_id      = stall_q;
    assign stall_ex      = stall_q;
    assign flush_if      = flush_q;
    assign flush_id      = flush_q;
    assign flush_ex      = flush_q;
    assign trap_misalign = trap_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - scoreboard bench for branch_redirect_ctrl (STALL_CYCLES=2, CNT_W=2)
module tb_branch_redirect_ctrl;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_load_dep, cond_taken, stat_clr;
    logic [31:0]      ex_target;
    logic             pc_sel, stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex, trap_misalign;
    logic [31:0]      pc_target;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.STALL_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_load_dep(ex_load_dep),
        .cond_taken(cond_taken), .ex_target(ex_target), .stat_clr(stat_clr),
        .pc_sel(pc_sel), .pc_target(pc_target), .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .trap_misalign(trap_misalign), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    // Observed vector: {pc_sel, stall_if/id/ex, flush_if/id/ex, trap, pc_target, branch_cnt, taken_cnt}
    logic [43:0] obs;
    assign obs = {pc_sel, stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex, trap_misalign,
                  pc_target, branch_cnt, taken_cnt};

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_RED  = 8'b1000_1110;
    localparam logic [7:0] C_STL  = 8'b0111_0000;
    localparam logic [7:0] C_TRAP = 8'b0000_0001;

    // Stimulus word: {valid, branch, jal, jalr, load_dep, cond_taken, stat_clr}
    localparam logic [6:0] S_IDLE    = 7'b0000_000;
    localparam logic [6:0] S_BR_T    = 7'b1100_010;
    localparam logic [6:0] S_BR_N    = 7'b1100_000;
    localparam logic [6:0] S_BR_DEPT = 7'b1100_110;
    localparam logic [6:0] S_JAL     = 7'b1010_000;
    localparam logic [6:0] S_JALR    = 7'b1001_000;
    localparam logic [6:0] S_JAL_DEP = 7'b1010_100;
    localparam logic [6:0] S_CLR     = 7'b0000_001;
    localparam logic [6:0] S_JAL_CLR = 7'b1010_001;
    localparam logic [6:0] S_INVALID = 7'b0110_010;
    localparam logic [6:0] S_BJ_DEP  = 7'b1101_100;
    localparam logic [6:0] S_BJ      = 7'b1101_000;

    typedef struct {
        logic [6:0]  s;
        logic [31:0] tgt;
        logic [43:0] e;
    } row_t;

    logic [43:0] sb[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [43:0] mk(input logic [7:0] c, input logic [31:0] t, input int b, input int k);
        return {c, t, 2'(b), 2'(k)};
    endfunction

    task automatic apply(input logic [6:0] s, input logic [31:0] t);
        {ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_load_dep, cond_taken, stat_clr} = s;
        ex_target = t;
    endtask

    task automatic test_reset();
        logic [43:0] e;
        rst_n = 1'b0;
        apply(S_IDLE, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 44'h0) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, 44'h0); end
        @(negedge clk) rst_n = 1'b1;
        apply(S_JAL, 32'h40);
        sb.push_back(mk(C_RED, 32'h40, 1, 1));
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_pre_redirect: got %h expected %h", obs, e); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 44'h0) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, 44'h0); end
        apply(S_IDLE, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== 44'h0) begin errors++; $display("FAIL reset_run: got %h expected %h", obs, 44'h0); end
    endtask

    task automatic test_beq_taken();
        row_t rows[$];
        logic [43:0] e;
        rows.push_back('{S_BR_T, 32'h100, mk(C_RED,  32'h100, 1, 1)});
        rows.push_back('{S_JAL,  32'h300, mk(C_NONE, 32'h100, 1, 1)});
        rows.push_back('{S_IDLE, 32'h0,   mk(C_NONE, 32'h100, 1, 1)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].tgt);
            sb.push_back(rows[i].e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL beq_taken[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_bne_not_taken();
        row_t rows[$];
        logic [43:0] e;
        rows.push_back('{S_CLR,     32'h0,   mk(C_NONE, 32'h100, 0, 0)});
        rows.push_back('{S_BR_N,    32'h500, mk(C_NONE, 32'h100, 1, 0)});
        rows.push_back('{S_INVALID, 32'h600, mk(C_NONE, 32'h100, 1, 0)});
        rows.push_back('{S_IDLE,    32'h0,   mk(C_NONE, 32'h100, 1, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].tgt);
            sb.push_back(rows[i].e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL bne_not_taken[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic [43:0] e;
        rows.push_back('{S_BR_DEPT, 32'h200, mk(C_STL,  32'h100, 1, 0)});
        rows.push_back('{S_BR_DEPT, 32'h200, mk(C_STL,  32'h100, 1, 0)});
        rows.push_back('{S_BR_T,    32'h200, mk(C_NONE, 32'h100, 1, 0)});
        rows.push_back('{S_BR_T,    32'h200, mk(C_RED,  32'h200, 2, 1)});
        rows.push_back('{S_IDLE,    32'h0,   mk(C_NONE, 32'h200, 2, 1)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].tgt);
            sb.push_back(rows[i].e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL load_use[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_misalign();
        row_t rows[$];
        logic [43:0] e;
        rows.push_back('{S_CLR,     32'h0,   mk(C_NONE, 32'h200, 0, 0)});
        rows.push_back('{S_JALR,    32'h102, mk(C_TRAP, 32'h200, 1, 0)});
        rows.push_back('{S_IDLE,    32'h0,   mk(C_NONE, 32'h200, 1, 0)});
        rows.push_back('{S_JAL_DEP, 32'h400, mk(C_RED,  32'h400, 2, 1)});
        rows.push_back('{S_IDLE,    32'h0,   mk(C_NONE, 32'h400, 2, 1)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].tgt);
            sb.push_back(rows[i].e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL misalign[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_saturate();
        row_t rows[$];
        logic [43:0] e;
        rows.push_back('{S_CLR, 32'h0, mk(C_NONE, 32'h400, 0, 0)});
        for (int j = 1; j <= 5; j++) begin
            rows.push_back('{S_JAL,  32'(j * 16), mk(C_RED,  32'(j * 16), (j > 3) ? 3 : j, (j > 3) ? 3 : j)});
            rows.push_back('{S_IDLE, 32'h0,       mk(C_NONE, 32'(j * 16), (j > 3) ? 3 : j, (j > 3) ? 3 : j)});
        end
        rows.push_back('{S_JAL_CLR, 32'h60, mk(C_RED,  32'h60, 0, 0)});
        rows.push_back('{S_IDLE,    32'h0,  mk(C_NONE, 32'h60, 0, 0)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].tgt);
            sb.push_back(rows[i].e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL saturate[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [43:0] e;
        rows.push_back('{S_BJ_DEP, 32'h800, mk(C_STL,  32'h60,  0, 0)});
        rows.push_back('{S_BJ_DEP, 32'h800, mk(C_STL,  32'h60,  0, 0)});
        rows.push_back('{S_BJ_DEP, 32'h800, mk(C_NONE, 32'h60,  0, 0)});
        rows.push_back('{S_BJ_DEP, 32'h800, mk(C_STL,  32'h60,  0, 0)});
        rows.push_back('{S_BJ_DEP, 32'h800, mk(C_STL,  32'h60,  0, 0)});
        rows.push_back('{S_BJ,     32'h800, mk(C_NONE, 32'h60,  0, 0)});
        rows.push_back('{S_BJ,     32'h800, mk(C_RED,  32'h800, 1, 1)});
        rows.push_back('{S_IDLE,   32'h0,   mk(C_NONE, 32'h800, 1, 1)});
        foreach (rows[i]) begin
            apply(rows[i].s, rows[i].tgt);
            sb.push_back(rows[i].e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_load_use();
        test_misalign();
        test_saturate();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
